// File: rtl/adder_axis_pkg.sv
// Shared widths, operand field offsets and pending-flag encoding
// for the AXI-Stream adder and its operand splitter.
package adder_axis_pkg;

   // Round a bit width up to whole bytes, as AXI-Stream tdata requires.
   function automatic int axis_width(input int w);
      return ((w + 7) / 8) * 8;
   endfunction

   function automatic int op1_lsb(input int w);
      return 0 * w;
   endfunction

   function automatic int op2_lsb(input int w);
      return w;
   endfunction

   // {pend1, pend2}
   typedef enum logic [1:0] {
      PEND_EMPTY = 2'b00,
      PEND_ONLY2 = 2'b01,
      PEND_ONLY1 = 2'b10,
      PEND_BOTH  = 2'b11
   } pend_t;

endpackage

// File: rtl/operand_split_skid.sv
// One-entry skid register with a registered upstream ready.
// Cuts the combinational path from downstream ready to in_ready.
module operand_split_skid #(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic         full_q, full_d;
   logic         rdy_q, rdy_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_take;

   always_comb begin
      in_take   = in_valid & rdy_q;
      out_valid = full_q | in_take;
      out_data  = full_q ? skid_q : in_data;
      full_d    = full_q;
      skid_d    = skid_q;
      if (full_q) begin
         if (out_ready) full_d = 1'b0;
      end else if (in_take && !out_ready) begin
         full_d = 1'b1;
         skid_d = in_data;
      end
      rdy_d = ~full_d;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         full_q <= 1'b0;
         rdy_q  <= 1'b0;
         skid_q <= '0;
      end else begin
         full_q <= full_d;
         rdy_q  <= rdy_d;
         skid_q <= skid_d;
      end
   end

   assign in_ready = rdy_q;

endmodule

// File: rtl/operand_axis_split.sv
// Splits a packed operand pair into two independently handshaked
// AXI-Stream outputs. OPERAND_SPLIT_SKID_EN adds a registered-ready skid.
module operand_axis_split
   import adder_axis_pkg::*;
#(
   parameter int ADDER_WIDTH    = 4,
   parameter int IN_AXIS_WIDTH  = axis_width(2 * ADDER_WIDTH),
   parameter int OUT_AXIS_WIDTH = axis_width(ADDER_WIDTH)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [IN_AXIS_WIDTH-1:0]  data_i_tdata,
   input  logic                      data_i_tvalid,
   output logic                      data_i_tready,
   output logic [OUT_AXIS_WIDTH-1:0] data1_o_tdata,
   output logic                      data1_o_tvalid,
   input  logic                      data1_o_tready,
   output logic [OUT_AXIS_WIDTH-1:0] data2_o_tdata,
   output logic                      data2_o_tvalid,
   input  logic                      data2_o_tready
);

   localparam int PW  = 2 * ADDER_WIDTH;
   localparam int L1  = op1_lsb(ADDER_WIDTH);
   localparam int L2  = op2_lsb(ADDER_WIDTH);

   pend_t            pend_q, pend_d;
   logic [PW-1:0]    hold_q, hold_d;
   logic             pend1, pend2;
   logic             hs1, hs2;
   logic             load_ok, acc;
   logic             up_valid;
   logic [PW-1:0]    up_data;
   logic             unused_in;

   assign unused_in = ^data_i_tdata;

`ifdef OPERAND_SPLIT_SKID_EN
   operand_split_skid #(
      .W (PW)
   ) u_skid (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_data   (data_i_tdata[PW-1:0]),
      .in_valid  (data_i_tvalid),
      .in_ready  (data_i_tready),
      .out_data  (up_data),
      .out_valid (up_valid),
      .out_ready (load_ok)
   );
`else
   assign up_data       = data_i_tdata[PW-1:0];
   assign up_valid      = data_i_tvalid;
   assign data_i_tready = load_ok;
`endif

   assign pend1 = pend_q[1];
   assign pend2 = pend_q[0];

   // hold may be refilled once every pending operand leaves this cycle
   always_comb begin
      hs1     = pend1 & data1_o_tready;
      hs2     = pend2 & data2_o_tready;
      load_ok = (~pend1 | data1_o_tready) & (~pend2 | data2_o_tready);
      acc     = up_valid & load_ok;
      hold_d  = hold_q;
      pend_d  = pend_t'({pend1 & ~hs1, pend2 & ~hs2});
      if (acc) begin
         hold_d = up_data;
         pend_d = PEND_BOTH;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pend_q <= PEND_EMPTY;
         hold_q <= '0;
      end else begin
         pend_q <= pend_d;
         hold_q <= hold_d;
      end
   end

   assign data1_o_tvalid = pend1;
   assign data2_o_tvalid = pend2;
   assign data1_o_tdata  = OUT_AXIS_WIDTH'(hold_q[L1 +: ADDER_WIDTH]);
   assign data2_o_tdata  = OUT_AXIS_WIDTH'(hold_q[L2 +: ADDER_WIDTH]);

endmodule
